// File: rtl/usb_sof_presence_mon.sv
// Host-presence and frame-timing monitor: tracks DETACHED/ACTIVE/SUSPENDED from SOF tokens,
// synthesises frame ticks for missed SOFs and counts missed frames and index/timing errors.
module usb_sof_presence_mon #(
    parameter int SOF_PERIOD_CYC = 48000,
    parameter int SOF_TOL_CYC    = 240,
    parameter int MISS_LIMIT     = 3,
    parameter int TIMEOUT_CYC    = 48000000,
    parameter int CNT_W          = 8
) (
    input  logic             clk_48mhz,
    input  logic             reset,
    input  logic             sof_valid,
    input  logic [10:0]      frame_index,
    input  logic             clr_cnt,
    output logic             host_present,
    output logic             suspended,
    output logic [1:0]       state,
    output logic             frame_tick,
    output logic [10:0]      frame_est,
    output logic             resume,
    output logic [CNT_W-1:0] missed_sof_cnt,
    output logic [CNT_W-1:0] frame_err_cnt
);

    localparam logic [1:0] ST_DETACHED  = 2'd0;
    localparam logic [1:0] ST_ACTIVE    = 2'd1;
    localparam logic [1:0] ST_SUSPENDED = 2'd2;

    localparam int CYC_W  = $clog2(SOF_PERIOD_CYC + SOF_TOL_CYC + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam int MR_W   = $clog2(MISS_LIMIT + 1);

    localparam logic [CYC_W-1:0]  CYC_EARLY   = CYC_W'(SOF_PERIOD_CYC - SOF_TOL_CYC);
    localparam logic [CYC_W-1:0]  CYC_WIN     = CYC_W'(SOF_PERIOD_CYC + SOF_TOL_CYC - 1);
    localparam logic [CYC_W-1:0]  CYC_REALIGN = CYC_W'(SOF_TOL_CYC);
    localparam logic [CYC_W-1:0]  CYC_MAX     = '1;
    localparam logic [IDLE_W-1:0] IDLE_LAST   = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [MR_W-1:0]   MR_LAST     = MR_W'(MISS_LIMIT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    logic [1:0]        state_q, state_d;
    logic [10:0]       est_q, est_d;
    logic              tick_q, tick_d;
    logic              resume_q, resume_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d, cyc_inc;
    logic [IDLE_W-1:0] idle_q, idle_d, idle_inc;
    logic [MR_W-1:0]   mrun_q, mrun_d;
    logic [CNT_W-1:0]  miss_q, miss_d, err_q, err_d;
    logic              miss_inc, err_inc;

    assign cyc_inc  = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + 1'b1;
    assign idle_inc = (idle_q == IDLE_LAST) ? idle_q : idle_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        est_d    = est_q;
        tick_d   = 1'b0;
        resume_d = 1'b0;
        cyc_d    = cyc_inc;
        idle_d   = idle_inc;
        mrun_d   = mrun_q;
        miss_inc = 1'b0;
        err_inc  = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                // Priority: real SOF, then presence timeout, then frame-window expiry.
                if (sof_valid) begin
                    tick_d  = 1'b1;
                    est_d   = frame_index;
                    cyc_d   = '0;
                    idle_d  = '0;
                    mrun_d  = '0;
                    err_inc = (frame_index != est_q + 11'd1) || (cyc_q < CYC_EARLY);
                end else if (idle_q == IDLE_LAST) begin
                    state_d = ST_DETACHED;
                    cyc_d   = '0;
                    idle_d  = '0;
                    mrun_d  = '0;
                end else if (cyc_q == CYC_WIN) begin
                    tick_d   = 1'b1;
                    est_d    = est_q + 11'd1;
                    cyc_d    = CYC_REALIGN;
                    miss_inc = 1'b1;
                    mrun_d   = mrun_q + 1'b1;
                    if (mrun_q == MR_LAST)
                        state_d = ST_SUSPENDED;
                end
            end
            ST_SUSPENDED: begin
                if (sof_valid) begin
                    state_d  = ST_ACTIVE;
                    tick_d   = 1'b1;
                    resume_d = 1'b1;
                    est_d    = frame_index;
                    cyc_d    = '0;
                    idle_d   = '0;
                    mrun_d   = '0;
                end else if (idle_q == IDLE_LAST) begin
                    state_d = ST_DETACHED;
                    cyc_d   = '0;
                    idle_d  = '0;
                    mrun_d  = '0;
                end
            end
            default: begin
                cyc_d  = '0;
                idle_d = '0;
                mrun_d = '0;
                if (sof_valid) begin
                    state_d = ST_ACTIVE;
                    tick_d  = 1'b1;
                    est_d   = frame_index;
                end else begin
                    state_d = ST_DETACHED;
                end
            end
        endcase

        // Clear wins over a same-cycle increment.
        if (clr_cnt)                           miss_d = '0;
        else if (miss_inc && miss_q != CNT_MAX) miss_d = miss_q + 1'b1;
        else                                    miss_d = miss_q;
        if (clr_cnt)                           err_d = '0;
        else if (err_inc && err_q != CNT_MAX)   err_d = err_q + 1'b1;
        else                                    err_d = err_q;
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q  <= ST_DETACHED;
            est_q    <= '0;
            tick_q   <= 1'b0;
            resume_q <= 1'b0;
            cyc_q    <= '0;
            idle_q   <= '0;
            mrun_q   <= '0;
            miss_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            est_q    <= est_d;
            tick_q   <= tick_d;
            resume_q <= resume_d;
            cyc_q    <= cyc_d;
            idle_q   <= idle_d;
            mrun_q   <= mrun_d;
            miss_q   <= miss_d;
            err_q    <= err_d;
        end
    end

    assign state          = state_q;
    assign host_present   = (state_q != ST_DETACHED);
    assign suspended      = (state_q == ST_SUSPENDED);
    assign frame_tick     = tick_q;
    assign frame_est      = est_q;
    assign resume         = resume_q;
    assign missed_sof_cnt = miss_q;
    assign frame_err_cnt  = err_q;

endmodule

// File: tb/tb_usb_sof_presence_mon.sv
// Scoreboard bench for usb_sof_presence_mon: stimulus queues expected frame ticks,
// a monitor pops and compares on every frame_tick.
module tb_usb_sof_presence_mon;

    logic        clk_48mhz = 1'b0;
    logic        reset = 1'b1;
    logic        sof_valid = 1'b0;
    logic [10:0] frame_index = '0;
    logic        clr_cnt = 1'b0;
    logic        host_present, suspended, frame_tick, resume;
    logic [1:0]  state;
    logic [10:0] frame_est;
    logic [3:0]  missed_sof_cnt, frame_err_cnt;

    usb_sof_presence_mon #(
        .SOF_PERIOD_CYC(100), .SOF_TOL_CYC(5), .MISS_LIMIT(3),
        .TIMEOUT_CYC(1000), .CNT_W(4)
    ) dut (
        .clk_48mhz(clk_48mhz), .reset(reset), .sof_valid(sof_valid),
        .frame_index(frame_index), .clr_cnt(clr_cnt),
        .host_present(host_present), .suspended(suspended), .state(state),
        .frame_tick(frame_tick), .frame_est(frame_est), .resume(resume),
        .missed_sof_cnt(missed_sof_cnt), .frame_err_cnt(frame_err_cnt)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    int cyc = 0;
    always @(posedge clk_48mhz) cyc <= cyc + 1;

    typedef struct {
        int          edge_n;
        logic [1:0]  st;
        logic [10:0] est;
        logic [3:0]  miss;
        logic [3:0]  err;
        logic        res;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    task automatic push(input int e, input int st, input int est, input int miss,
                        input int err, input int res);
        exp_t x;
        x.edge_n = e;
        x.st     = 2'(st);
        x.est    = 11'(est);
        x.miss   = 4'(miss);
        x.err    = 4'(err);
        x.res    = 1'(res);
        q.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Drive one SOF so that the DUT samples it on posedge number e.
    task automatic sof_at(input int e, input int idx, input logic clr);
        if (cyc > e - 1) begin
            tests++;
            fails++;
            $display("FAIL sched: cycle %0d already past %0d", cyc, e - 1);
        end
        while (cyc < e - 1) @(negedge clk_48mhz);
        sof_valid   = 1'b1;
        frame_index = 11'(idx);
        clr_cnt     = clr;
        @(negedge clk_48mhz);
        sof_valid = 1'b0;
        clr_cnt   = 1'b0;
    endtask

    // Monitor: every frame_tick must match the next queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk_48mhz);
            #1;
            if (resume && !frame_tick) begin
                tests++;
                fails++;
                $display("FAIL resume_without_tick at cycle %0d", cyc);
            end
            if (frame_tick) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_tick at cycle %0d est=%0d", cyc, frame_est);
                end else begin
                    x = q.pop_front();
                    if (cyc != x.edge_n || state !== x.st || frame_est !== x.est ||
                        missed_sof_cnt !== x.miss || frame_err_cnt !== x.err ||
                        resume !== x.res || host_present !== (x.st != 2'd0) ||
                        suspended !== (x.st == 2'd2)) begin
                        fails++;
                        $display("FAIL tick: got cyc=%0d st=%0d est=%0d miss=%0d err=%0d res=%0d hp=%0d sus=%0d; want cyc=%0d st=%0d est=%0d miss=%0d err=%0d res=%0d",
                                 cyc, state, frame_est, missed_sof_cnt, frame_err_cnt, resume,
                                 host_present, suspended,
                                 x.edge_n, x.st, x.est, x.miss, x.err, x.res);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e20, e22, e500, f, g, h;
        repeat (3) @(negedge clk_48mhz);
        reset = 1'b0;
        @(negedge clk_48mhz);
        chk("reset_state", 32'({state, host_present, suspended, frame_tick, resume,
                                frame_est, missed_sof_cnt, frame_err_cnt}), 32'd0);

        // Regular SOF train, first one leaves DETACHED.
        e0 = cyc + 5;
        for (int k = 10; k <= 20; k++) begin
            push(e0 + 100 * (k - 10), 1, k, 0, 0, 0);
            sof_at(e0 + 100 * (k - 10), k, 1'b0);
        end

        // One dropped SOF, then realigned real SOF.
        e20 = e0 + 1000;
        push(e20 + 105, 1, 21, 1, 0, 0);
        e22 = e20 + 200;
        push(e22, 1, 22, 1, 0, 0);
        sof_at(e22, 22, 1'b0);

        // Three misses suspend, then resume with a jump in index.
        push(e22 + 105, 1, 23, 2, 0, 0);
        push(e22 + 205, 1, 24, 3, 0, 0);
        push(e22 + 305, 2, 25, 4, 0, 0);
        e500 = e22 + 400;
        push(e500, 1, 500, 4, 0, 1);
        sof_at(e500, 500, 1'b0);

        // Suspend again and run into the presence timeout.
        push(e500 + 105, 1, 501, 5, 0, 0);
        push(e500 + 205, 1, 502, 6, 0, 0);
        push(e500 + 305, 2, 503, 7, 0, 0);
        while (cyc < e500 + 999) @(negedge clk_48mhz);
        chk("pre_timeout_state", 32'(state), 32'd2);
        @(negedge clk_48mhz);
        chk("timeout_detached", 32'({state, host_present, suspended}), 32'd0);

        // Index skip, early SOF, then saturation of the error counter.
        f = cyc + 10;
        push(f, 1, 30, 7, 0, 0);        sof_at(f, 30, 1'b0);
        push(f + 100, 1, 40, 7, 1, 0);  sof_at(f + 100, 40, 1'b0);
        push(f + 150, 1, 41, 7, 2, 0);  sof_at(f + 150, 41, 1'b0);
        for (int i = 0; i < 18; i++) begin
            push(f + 160 + 10 * i, 1, 42 + i, 7, (3 + i > 15) ? 15 : 3 + i, 0);
            sof_at(f + 160 + 10 * i, 42 + i, 1'b0);
        end
        chk("err_saturated", 32'(frame_err_cnt), 32'd15);

        // Clear coincident with an error increment, SOF exactly at window expiry, fresh error.
        g = f + 340;
        push(g, 1, 60, 0, 0, 0);        sof_at(g, 60, 1'b1);
        h = g + 105;
        push(h, 1, 61, 0, 0, 0);        sof_at(h, 61, 1'b0);
        push(h + 50, 1, 62, 0, 1, 0);   sof_at(h + 50, 62, 1'b0);

        // Reset together with a SOF: the tick must be dropped.
        repeat (3) @(negedge clk_48mhz);
        sof_valid   = 1'b1;
        frame_index = 11'd70;
        reset       = 1'b1;
        @(negedge clk_48mhz);
        sof_valid = 1'b0;
        chk("mid_reset", 32'({state, host_present, frame_tick, frame_est,
                              missed_sof_cnt, frame_err_cnt}), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk_48mhz);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
